// File: rtl/life_step_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | life_step_engine: one Game of Life generation on a toroidal grid, read    |
// | from the display bank and written to the back bank. Revision: 1.0        |
// +----------------------------------------------------------------------------+
module life_step_engine #(
    parameter int WIDTH  = 40,
    parameter int HEIGHT = 30
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [9:0]  rd_x,
    output logic [8:0]  rd_y,
    input  logic        rd_data,
    output logic        wr_en,
    output logic [9:0]  wr_x,
    output logic [8:0]  wr_y,
    output logic        wr_data,
    output logic        swap,
    output logic        busy,
    output logic        done,
    output logic [15:0] gen_count
);
    localparam logic [9:0] c_X_LAST = 10'(WIDTH - 1);
    localparam logic [8:0] c_Y_LAST = 9'(HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LAST  = 3'd2,
        S_WRITE = 3'd3,
        S_SWAP  = 3'd4
    } state_t;

    state_t     r_state;
    logic [3:0] r_k;
    logic [9:0] r_cx;
    logic [8:0] r_cy;
    logic [3:0] r_n;
    logic       r_self;

    logic [9:0] w_nx, w_bx, w_ax;
    logic [8:0] w_ny, w_by, w_ay;
    logic [3:0] w_idx, w_cap_idx, w_n_next;
    logic       w_is_nb, w_self_next, w_next_cell;

    assign w_nx = (r_cx == c_X_LAST) ? 10'd0 : r_cx + 10'd1;
    assign w_ny = (r_cx != c_X_LAST) ? r_cy :
                  (r_cy == c_Y_LAST) ? 9'd0 : r_cy + 9'd1;

    // Window address: in WRITE it targets k=0 of the cell the cursor moves to.
    always_comb begin
        w_bx  = r_cx;
        w_by  = r_cy;
        if (r_state == S_WRITE) begin
            w_bx = w_nx;
            w_by = w_ny;
        end
        w_idx = (r_state == S_READ) ? r_k + 4'd1 : 4'd0;
        w_ax  = w_bx;
        w_ay  = w_by;
        case (w_idx)
            4'd0, 4'd3, 4'd6: w_ax = (w_bx == 10'd0) ? c_X_LAST : w_bx - 10'd1;
            4'd2, 4'd5, 4'd8: w_ax = (w_bx == c_X_LAST) ? 10'd0 : w_bx + 10'd1;
            default: ;
        endcase
        case (w_idx)
            4'd0, 4'd1, 4'd2: w_ay = (w_by == 9'd0) ? c_Y_LAST : w_by - 9'd1;
            4'd6, 4'd7, 4'd8: w_ay = (w_by == c_Y_LAST) ? 9'd0 : w_by + 9'd1;
            default: ;
        endcase
    end

    // Data arriving now belongs to the address issued one cycle earlier.
    assign w_cap_idx   = (r_state == S_LAST) ? 4'd8 : r_k - 4'd1;
    assign w_is_nb     = (w_cap_idx != 4'd4);
    assign w_n_next    = r_n + {3'b000, rd_data & w_is_nb};
    assign w_self_next = w_is_nb ? r_self : rd_data;
    assign w_next_cell = (w_n_next == 4'd3) | (w_self_next & (w_n_next == 4'd2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_k       <= 4'd0;
            r_cx      <= 10'd0;
            r_cy      <= 9'd0;
            r_n       <= 4'd0;
            r_self    <= 1'b0;
            rd_x      <= 10'd0;
            rd_y      <= 9'd0;
            wr_en     <= 1'b0;
            wr_x      <= 10'd0;
            wr_y      <= 9'd0;
            wr_data   <= 1'b0;
            swap      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            gen_count <= 16'd0;
        end else begin
            wr_en <= 1'b0;
            swap  <= 1'b0;
            done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_READ;
                        busy    <= 1'b1;
                        r_k     <= 4'd0;
                        r_n     <= 4'd0;
                        r_self  <= 1'b0;
                        rd_x    <= w_ax;
                        rd_y    <= w_ay;
                    end
                end
                S_READ: begin
                    if (r_k != 4'd0) begin
                        r_n    <= w_n_next;
                        r_self <= w_self_next;
                    end
                    if (r_k == 4'd8) begin
                        r_state <= S_LAST;
                    end else begin
                        r_k  <= r_k + 4'd1;
                        rd_x <= w_ax;
                        rd_y <= w_ay;
                    end
                end
                S_LAST: begin
                    wr_en   <= 1'b1;
                    wr_x    <= r_cx;
                    wr_y    <= r_cy;
                    wr_data <= w_next_cell;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_n    <= 4'd0;
                    r_self <= 1'b0;
                    r_k    <= 4'd0;
                    r_cx   <= w_nx;
                    r_cy   <= w_ny;
                    if (r_cx == c_X_LAST && r_cy == c_Y_LAST) begin
                        r_state   <= S_SWAP;
                        swap      <= 1'b1;
                        done      <= 1'b1;
                        gen_count <= gen_count + 16'd1;
                    end else begin
                        r_state <= S_READ;
                        rd_x    <= w_ax;
                        rd_y    <= w_ay;
                    end
                end
                S_SWAP: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_life_step_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_life_step_engine: directed pattern table plus reset/hazard sequences   |
// | against a two-bank pixel memory model. Revision: 1.0                      |
// +----------------------------------------------------------------------------+
module tb_life_step_engine;
    localparam int c_W = 40;
    localparam int c_H = 30;

    logic        clk = 1'b0;
    logic        reset_n, start, rd_data;
    logic [9:0]  rd_x, wr_x;
    logic [8:0]  rd_y, wr_y;
    logic        wr_en, wr_data, swap, busy, done;
    logic [15:0] gen_count;

    life_step_engine #(.WIDTH(c_W), .HEIGHT(c_H)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .swap(swap), .busy(busy), .done(done), .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    logic mem [0:1][0:c_H-1][0:c_W-1];
    logic disp = 1'b0;

    always @(posedge clk) begin
        if (rd_x < 10'(c_W) && rd_y < 9'(c_H)) rd_data <= mem[disp][rd_y][rd_x];
        else rd_data <= 1'b0;
    end

    typedef struct packed {
        logic           reload;
        logic [2:0]     n_in;
        logic [3:0][5:0] in_x;
        logic [3:0][4:0] in_y;
        logic [2:0]     n_out;
        logic [3:0][5:0] out_x;
        logic [3:0][4:0] out_y;
    } vec_t;

    vec_t vecs [0:4];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_gen = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_cell(input int v, input bit is_out, input int x, input int y);
        if (is_out) begin
            vecs[v].out_x[vecs[v].n_out] = 6'(x);
            vecs[v].out_y[vecs[v].n_out] = 5'(y);
            vecs[v].n_out = vecs[v].n_out + 3'd1;
        end else begin
            vecs[v].in_x[vecs[v].n_in] = 6'(x);
            vecs[v].in_y[vecs[v].n_in] = 5'(y);
            vecs[v].n_in = vecs[v].n_in + 3'd1;
        end
    endtask

    function automatic bit is_live(input int v, input int x, input int y);
        for (int i = 0; i < 4; i++)
            if (i < int'(vecs[v].n_out) && int'(vecs[v].out_x[i]) == x && int'(vecs[v].out_y[i]) == y)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic load_vec(input int v);
        for (int b = 0; b < 2; b++)
            for (int y = 0; y < c_H; y++)
                for (int x = 0; x < c_W; x++)
                    mem[b][y][x] = 1'b0;
        for (int i = 0; i < int'(vecs[v].n_in); i++)
            mem[disp][vecs[v].in_y[i]][vecs[v].in_x[i]] = 1'b1;
    endtask

    // Runs one generation and checks timing, write order, data and the final image.
    task automatic run_gen(input int v, input bit poke);
        int swaps, swap_cyc, bad_ctl, bad_wr, bad_data, bad_rd, nwr, bad_img;
        int fx, fy, ex, ey, k, idx;
        bit exp_wr;
        logic back;
        swaps = 0; swap_cyc = -1; bad_ctl = 0; bad_wr = 0; bad_data = 0;
        bad_rd = 0; nwr = 0; bad_img = 0; fx = -1; fy = -1;
        if (vecs[v].reload) load_vec(v);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 13205; c++) begin
            if (busy !== (c <= 13201)) bad_ctl++;
            if (done !== swap) bad_ctl++;
            if (swap === 1'b1) begin
                swaps++;
                swap_cyc = c;
            end
            exp_wr = (c % 11 == 0) && (c <= 13200);
            if (wr_en !== exp_wr) bad_wr++;
            if (wr_en === 1'b1) begin
                nwr++;
                idx = c / 11 - 1;
                ex = idx % c_W;
                ey = idx / c_W;
                if (int'(wr_x) != ex || int'(wr_y) != ey) bad_wr++;
                if (wr_data !== is_live(v, ex, ey)) begin
                    if (bad_data == 0) begin fx = ex; fy = ey; end
                    bad_data++;
                end
                back = ~disp;
                if (wr_x < 10'(c_W) && wr_y < 9'(c_H)) mem[back][wr_y][wr_x] = wr_data;
            end
            if (c <= 9) begin
                k = c - 1;
                ex = (k % 3 == 0) ? c_W - 1 : (k % 3 == 1) ? 0 : 1;
                ey = (k / 3 == 0) ? c_H - 1 : (k / 3 == 1) ? 0 : 1;
                if (int'(rd_x) != ex || int'(rd_y) != ey) bad_rd++;
            end
            if (swap === 1'b1) disp = ~disp;
            start = (poke && c == 500);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        for (int y = 0; y < c_H; y++)
            for (int x = 0; x < c_W; x++)
                if (mem[disp][y][x] !== is_live(v, x, y)) bad_img++;
        exp_gen++;
        check($sformatf("v%0d swap_count", v), swaps, 1);
        check($sformatf("v%0d swap_cycle", v), swap_cyc, 13201);
        check($sformatf("v%0d busy_done_timing", v), bad_ctl, 0);
        check($sformatf("v%0d write_sequence", v), bad_wr, 0);
        check($sformatf("v%0d write_count", v), nwr, c_W * c_H);
        check($sformatf("v%0d next_data first_bad=(%0d,%0d)", v, fx, fy), bad_data, 0);
        check($sformatf("v%0d read_window_cell0", v), bad_rd, 0);
        check($sformatf("v%0d bank_image", v), bad_img, 0);
        check($sformatf("v%0d gen_count", v), int'(gen_count), exp_gen);
    endtask

    initial begin
        int bad_rst;
        reset_n = 1'b0;
        start   = 1'b0;

        for (int i = 0; i < 5; i++) vecs[i] = '0;
        vecs[0].reload = 1'b1;                      // all-dead grid
        vecs[1].reload = 1'b1;                      // horizontal blinker
        add_cell(1, 0, 10, 10); add_cell(1, 0, 11, 10); add_cell(1, 0, 12, 10);
        add_cell(1, 1, 11, 9);  add_cell(1, 1, 11, 10); add_cell(1, 1, 11, 11);
        vecs[2].reload = 1'b0;                      // blinker second generation
        add_cell(2, 1, 10, 10); add_cell(2, 1, 11, 10); add_cell(2, 1, 12, 10);
        vecs[3].reload = 1'b1;                      // vertical blinker on x=0
        add_cell(3, 0, 0, 9);   add_cell(3, 0, 0, 10);  add_cell(3, 0, 0, 11);
        add_cell(3, 1, 39, 10); add_cell(3, 1, 0, 10);  add_cell(3, 1, 1, 10);
        vecs[4].reload = 1'b1;                      // block split across all corners
        add_cell(4, 0, 0, 0);   add_cell(4, 0, 39, 0);  add_cell(4, 0, 0, 29); add_cell(4, 0, 39, 29);
        add_cell(4, 1, 0, 0);   add_cell(4, 1, 39, 0);  add_cell(4, 1, 0, 29); add_cell(4, 1, 39, 29);
        load_vec(0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset busy", int'(busy), 0);
        check("reset swap_done", int'({swap, done}), 0);
        check("reset wr_en", int'(wr_en), 0);
        check("reset gen_count", int'(gen_count), 0);
        check("reset rd_addr", int'({rd_x, rd_y}), 0);

        for (int v = 1; v <= 4; v++) run_gen(v, v == 1);

        // Reset in the middle of a generation.
        load_vec(0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5999) @(posedge clk);
        #1;
        check("midgen busy_before_reset", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        exp_gen = 0;
        check("async_reset wr_en", int'(wr_en), 0);
        check("async_reset busy", int'(busy), 0);
        check("async_reset swap", int'(swap), 0);
        check("async_reset gen_count", int'(gen_count), 0);
        bad_rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (swap !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad_rst++;
        end
        check("reset_hold no_swap", bad_rst, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset idle", int'({busy, swap, done}), 0);

        run_gen(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/life_step_engine.md
# life_step_engine

Computes one Conway's Game of Life generation over a WIDTH×HEIGHT toroidal cell grid. It reads the current generation from the pixel memory's display bank through a 1-cycle-latency read port and writes the next generation into the back bank. On completion it pulses `swap` so the pixel memory flips banks, which changes what the video driver shows. It sits directly upstream of the pixel memory and runs once per `start` pulse.

## Interface
- WIDTH, 40, grid columns (x range 0..WIDTH-1)
- HEIGHT, 30, grid rows (y range 0..HEIGHT-1)
- clk  in  1  system clock (CLOCK_50 domain); single clock, no other clocks
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request one generation; sampled only in IDLE
- rd_x  out  10  current-gen read column address
- rd_y  out  9  current-gen read row address
- rd_data  in  1  cell at the (rd_x, rd_y) presented on the previous cycle (1-cycle latency)
- wr_en  out  1  next-gen write strobe, one cycle per cell
- wr_x  out  10  write column
- wr_y  out  9  write row
- wr_data  out  1  next-gen cell state
- swap  out  1  one-cycle pulse: next generation complete, flip banks
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, coincident with swap
- gen_count  out  16  generations completed since reset

## Operation
- All outputs are registered. On reset all outputs are 0, the FSM is in IDLE, and the cell cursor is (0,0).
- FSM states:
  - IDLE: leave when `start`=1; go to READ.
  - READ: 9 cycles.
  - LAST: 1 cycle.
  - WRITE: 1 cycle. Go to READ for the next cell, or to SWAP after cell (WIDTH-1, HEIGHT-1).
  - SWAP: 1 cycle. Return to IDLE.
- Cells are visited in raster order: x fastest, then y. The cursor wraps to (0,0) after each generation.
- READ issues window index k=0..8, one per cycle, with dy=k/3-1 and dx=k%3-1. k=4 is the centre cell.
- Neighbour coordinates wrap toroidally:
  - x-1 at x=0 → WIDTH-1; x+1 at WIDTH-1 → 0.
  - The same rule applies to y with HEIGHT.
  - Wrapping uses compare/select, no modulo operator.
- rd_data is captured one cycle after its address is issued, in the READ cycles k=1..8 and in LAST.
  - k≠4 is added into a 4-bit neighbour count n (range 0..8).
  - k=4 is stored as `self`.
- Rule: next = (n==3) | (self & (n==2)).
- WRITE drives wr_en=1, wr_x/wr_y = cursor, wr_data = next. The accumulator clears for the next cell.
- SWAP drives swap=1 and done=1, and increments gen_count modulo 2^16 (65535 → 0).
- `start` while busy is ignored; it is not queued.
- Asynchronous reset mid-generation:
  - Immediately returns to IDLE, drives all outputs to 0, and clears gen_count.
  - No swap is issued; partial back-bank writes are abandoned.
- rd_x/rd_y hold their last value in IDLE, SWAP, and WRITE. wr_x/wr_y/wr_data hold between writes.

## Timing
- Cycle 0 is the posedge sampling start=1 in IDLE.
- For each cell: READ cycles 1..9 present k=0..8, LAST at cycle 10, WRITE at cycle 11. The next cell's k=0 is at cycle 12.
- Per-cell period is 11 cycles, so cell i is written at cycle 11·(i+1).
- With defaults:
  - The last write is at cycle 13200.
  - swap, done, and the gen_count increment are at cycle 13201.
  - busy is high for cycles 1..13201 and low from cycle 13202.
- A new start is accepted at the cycle-13202 edge at the earliest.
- Per generation: exactly WIDTH·HEIGHT wr_en pulses and exactly 9·WIDTH·HEIGHT read addresses.

## Test plan
- **All-dead grid:** start → 1200 writes, all wr_data=0, in raster order; swap=done=1 at cycle 13201; gen_count=1; busy=0 at cycle 13202.
- **Horizontal blinker** at (10,10),(11,10),(12,10): one generation → wr_data=1 exactly at (11,9),(11,10),(11,11), all others 0. Second generation (bench flips banks on swap) → original three cells live; gen_count=2.
- **Toroidal wrap:** vertical blinker at (0,9),(0,10),(0,11) → live exactly at (39,10),(0,10),(1,10).
- **Corner block** at (0,0),(39,0),(0,29),(39,29): still life across the wrap → those four cells live after one generation, all others 0.
- **Read-port protocol:** for cell (0,0), cycles 1..9 present rd addresses (39,29),(0,29),(1,29),(39,0),(0,0),(1,0),(39,1),(0,1),(1,1). The first wr_en is at cycle 11 with wr_x=0, wr_y=0.
- **Control hazards:** start asserted at cycle 500 while busy → no effect; swap occurs only once, at cycle 13201. Separate run: reset_n low at cycle 6000 → wr_en/busy/swap/gen_count are 0 at once, with no swap. After reset_n releases, start → first read again addresses (39,29) and the full 13201-cycle generation completes.
